// File: rtl/ir_pkg.sv
// ir_pkg: shared FSM state type, microsecond acceptance windows and
// counter widths for the NEC IR frame receiver.
// IR_REPEAT_EN: when defined, the repeat-code state is part of the enum.
package ir_pkg;

    localparam int unsigned US_W   = 14;
    localparam int unsigned BCNT_W = 6;

    localparam logic [US_W-1:0]   US_SAT   = 14'd16383;
    localparam logic [BCNT_W-1:0] LAST_BIT = 6'd31;

    localparam logic [US_W-1:0] LEAD_MARK_MIN  = 14'd8000;
    localparam logic [US_W-1:0] LEAD_MARK_MAX  = 14'd10000;
    localparam logic [US_W-1:0] LEAD_SPACE_MIN = 14'd4000;
    localparam logic [US_W-1:0] LEAD_SPACE_MAX = 14'd5000;
    localparam logic [US_W-1:0] RPT_SPACE_MIN  = 14'd1750;
    localparam logic [US_W-1:0] RPT_SPACE_MAX  = 14'd2750;
    localparam logic [US_W-1:0] MARK_MIN       = 14'd300;
    localparam logic [US_W-1:0] MARK_MAX       = 14'd800;
    localparam logic [US_W-1:0] ZERO_MIN       = 14'd300;
    localparam logic [US_W-1:0] ZERO_MAX       = 14'd800;
    localparam logic [US_W-1:0] ONE_MIN        = 14'd1200;
    localparam logic [US_W-1:0] ONE_MAX        = 14'd2200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_STOP_MARK
`ifdef IR_REPEAT_EN
        , ST_RPT_MARK
`endif
    } ir_state_e;

    function automatic logic in_win(
        input logic [US_W-1:0] w,
        input logic [US_W-1:0] lo,
        input logic [US_W-1:0] hi
    );
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// ir_pulse_timer: 2-FF synchronizer, edge detect, microsecond prescaler
// and saturating phase-width counter for the IR input.
// Ports: clk, reset (async, active-high), ir_n (raw, low = mark);
// mark_start (falling), mark_end (rising), width_us (width of the phase
// that the current edge ends). Not affected by IR_REPEAT_EN.
module ir_pulse_timer
    import ir_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ir_n,
    output logic            mark_start,
    output logic            mark_end,
    output logic [US_W-1:0] width_us
);

    localparam int unsigned DIV = CLK_HZ / 1_000_000;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    // [0],[1]: synchronizer; [2]: previous synchronized level
    logic [2:0]      sync_q, sync_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [US_W-1:0] cnt_q, cnt_d;
    logic            tick;
    logic            any_edge;

    always_comb begin
        sync_d     = {sync_q[1:0], ir_n};
        mark_start = sync_q[2] & ~sync_q[1];
        mark_end   = ~sync_q[2] & sync_q[1];
        any_edge   = mark_start | mark_end;
        tick       = (pre_q == PRE_LAST);
        // Prescaler restarts on each edge so every phase starts a full µs
        pre_d      = (any_edge || tick) ? '0 : pre_q + 1'b1;
        cnt_d      = cnt_q;
        if (any_edge) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != US_SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
        width_us   = cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 3'b111;
            pre_q  <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/ir_frame_receiver.sv
// ir_frame_receiver: NEC IR frame decoder; validates leader, 32 data bits
// and stop mark, emits the code word with a one-cycle strobe.
// Ports: clk, reset (async, active-high), ir_n (low = mark); code,
// code_valid, repeat_hit, err (one-cycle pulses), busy (FSM not idle).
// IR_REPEAT_EN: enables the repeat-code path; otherwise repeat_hit = 0.
module ir_frame_receiver
    import ir_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TIMEOUT_US = 12000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_n,
    output logic [31:0] code,
    output logic        code_valid,
    output logic        repeat_hit,
    output logic        err,
    output logic        busy
);

    localparam logic [US_W-1:0] TIMEOUT = US_W'(TIMEOUT_US);

    logic            mark_start;
    logic            mark_end;
    logic [US_W-1:0] width_us;

    ir_state_e         state_q, state_d;
    logic [31:0]       shift_q, shift_d;
    logic [31:0]       code_q, code_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
`ifdef IR_REPEAT_EN
    logic              have_q, have_d;
    logic              rpt_q, rpt_d;
`endif
    logic              fail;
    logic              mark_ok;
    logic              sp_zero;
    logic              sp_one;
    logic              timed_out;

    ir_pulse_timer #(
        .CLK_HZ (CLK_HZ)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .ir_n       (ir_n),
        .mark_start (mark_start),
        .mark_end   (mark_end),
        .width_us   (width_us)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        code_d    = code_q;
        bcnt_d    = bcnt_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        fail      = 1'b0;
`ifdef IR_REPEAT_EN
        have_d    = have_q;
        rpt_d     = 1'b0;
`endif
        mark_ok   = in_win(width_us, MARK_MIN, MARK_MAX);
        sp_zero   = in_win(width_us, ZERO_MIN, ZERO_MAX);
        sp_one    = in_win(width_us, ONE_MIN, ONE_MAX);
        // An edge in the same cycle takes precedence over the timeout
        timed_out = (width_us >= TIMEOUT) && !(mark_start || mark_end);

        unique case (state_q)
            ST_IDLE: begin
                if (mark_start) state_d = ST_LEAD_MARK;
            end
            ST_LEAD_MARK: begin
                if (mark_end) begin
                    if (in_win(width_us, LEAD_MARK_MIN, LEAD_MARK_MAX))
                        state_d = ST_LEAD_SPACE;
                    else
                        fail = 1'b1;
                end
            end
            ST_LEAD_SPACE: begin
                if (mark_start) begin
                    if (in_win(width_us, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                        bcnt_d  = '0;
                        state_d = ST_BIT_MARK;
                    end
`ifdef IR_REPEAT_EN
                    else if (in_win(width_us, RPT_SPACE_MIN, RPT_SPACE_MAX))
                        state_d = ST_RPT_MARK;
`endif
                    else begin
                        fail = 1'b1;
                    end
                end
            end
            ST_BIT_MARK: begin
                if (mark_end) begin
                    if (mark_ok) state_d = ST_BIT_SPACE;
                    else         fail    = 1'b1;
                end
            end
            ST_BIT_SPACE: begin
                if (mark_start) begin
                    if (sp_zero || sp_one) begin
                        shift_d = {shift_q[30:0], sp_one};
                        bcnt_d  = bcnt_q + 1'b1;
                        state_d = (bcnt_q == LAST_BIT) ? ST_STOP_MARK
                                                       : ST_BIT_MARK;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            ST_STOP_MARK: begin
                if (mark_end) begin
                    if (mark_ok) begin
                        code_d  = shift_q;
                        valid_d = 1'b1;
`ifdef IR_REPEAT_EN
                        have_d  = 1'b1;
`endif
                        state_d = ST_IDLE;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
`ifdef IR_REPEAT_EN
            ST_RPT_MARK: begin
                if (mark_end) begin
                    if (mark_ok) begin
                        // A repeat with nothing to repeat is an error
                        rpt_d   = have_q;
                        err_d   = ~have_q;
                        state_d = ST_IDLE;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && timed_out) fail = 1'b1;
        if (fail) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            code_q  <= '0;
            bcnt_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef IR_REPEAT_EN
            have_q  <= 1'b0;
            rpt_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            code_q  <= code_d;
            bcnt_q  <= bcnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
`ifdef IR_REPEAT_EN
            have_q  <= have_d;
            rpt_q   <= rpt_d;
`endif
        end
    end

    assign code       = code_q;
    assign code_valid = valid_q;
    assign err        = err_q;
    assign busy       = (state_q != ST_IDLE);
`ifdef IR_REPEAT_EN
    assign repeat_hit = rpt_q;
`else
    assign repeat_hit = 1'b0;
`endif

endmodule

// File: tb/tb_ir_frame_receiver.sv
// tb_ir_frame_receiver: randomized NEC frames against a phase-list
// reference model; a negedge monitor checks strobes from a queue.
module tb_ir_frame_receiver;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int          TO_US  = 12000;
`ifdef IR_REPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif
    localparam int K_VALID = 0;
    localparam int K_RPT   = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        int          kind;
        logic [31:0] code;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ir_n;
    logic [31:0] code;
    logic        code_valid;
    logic        repeat_hit;
    logic        err;
    logic        busy;

    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [31:0] model_code;
    bit          model_have;

    ir_frame_receiver #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TO_US)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ir_n       (ir_n),
        .code       (code),
        .code_valid (code_valid),
        .repeat_hit (repeat_hit),
        .err        (err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (code_valid || repeat_hit || err)) begin
            exp_t e;
            int   k;
            k = code_valid ? K_VALID : (repeat_hit ? K_RPT : K_ERR);
            chk("strobe_onehot", $countones({code_valid, repeat_hit, err}), 1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got kind %0d want none", k);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_kind", k, e.kind);
                chk("strobe_code", code, e.code);
                if (e.at >= 0) chk("strobe_cycle", cyc, e.at);
            end
        end
    end

    function automatic bit inw(input int w, input int lo, input int hi);
        return (w >= lo) && (w <= hi);
    endfunction

    // Widths sit a little above each window floor to keep runs short
    function automatic int pick(input int lo);
        return lo + 10 + int'($urandom_range(0, 50));
    endfunction

    function automatic void build(input logic [31:0] w, output int ph[$]);
        ph = {};
        ph.push_back(pick(8000));
        ph.push_back(pick(4000));
        for (int i = 31; i >= 0; i--) begin
            ph.push_back(pick(300));
            ph.push_back(w[i] ? pick(1200) : pick(300));
        end
        ph.push_back(pick(300));
    endfunction

    // Phase list: even index = mark, odd = space. Returns the phase whose
    // closing edge produces the event, or -1 when the list runs out and
    // the receiver is left to time out.
    function automatic void ref_model(input int ph[$], output int k,
                                      output int kind, output logic [31:0] w);
        int n;
        n    = ph.size();
        w    = '0;
        kind = K_ERR;
        k    = -1;
        if (!inw(ph[0], 8000, 10000)) begin k = 0; return; end
        if (n < 2) return;
        if (inw(ph[1], 4000, 5000)) begin
            for (int i = 0; i < 32; i++) begin
                int m;
                m = 2 + 2 * i;
                if (n <= m) return;
                if (!inw(ph[m], 300, 800)) begin k = m; return; end
                if (n <= m + 1) return;
                if (inw(ph[m+1], 300, 800))        w = {w[30:0], 1'b0};
                else if (inw(ph[m+1], 1200, 2200)) w = {w[30:0], 1'b1};
                else begin k = m + 1; return; end
            end
            if (n <= 66) return;
            k = 66;
            if (inw(ph[66], 300, 800)) kind = K_VALID;
            return;
        end
        if (inw(ph[1], 1750, 2750)) begin
            if (!RPT_EN) begin k = 1; return; end
            if (n <= 2) return;
            k = 2;
            if (inw(ph[2], 300, 800) && model_have) kind = K_RPT;
            return;
        end
        k = 1;
    endfunction

    task automatic drive(input int ph[$], input int k_ev, input exp_t e_in);
        exp_t e;
        e = e_in;
        for (int k = 0; k < ph.size(); k++) begin
            ir_n = (k % 2 == 0) ? 1'b0 : 1'b1;
            repeat (ph[k]) @(posedge clk);
            #1;
            if (k == k_ev) begin
                e.at = cyc + 3;
                exp_q.push_back(e);
            end
        end
        ir_n = 1'b1;
    endtask

    task automatic wait_drain(input int n);
        repeat (n) @(posedge clk);
        #1;
        chk("pending_expect", exp_q.size(), 0);
    endtask

    task automatic run(input int ph[$]);
        int          k_ev;
        int          kind;
        logic [31:0] w;
        exp_t        e;
        ref_model(ph, k_ev, kind, w);
        e.kind = kind;
        e.code = (kind == K_VALID) ? w : model_code;
        e.at   = -1;
        if (kind == K_VALID) begin
            model_code = w;
            model_have = 1'b1;
        end
        if (k_ev < 0) exp_q.push_back(e);
        drive(ph, k_ev, e);
        wait_drain((k_ev < 0) ? TO_US + 100 : 20);
    endtask

    initial begin
        int   ph[$];
        exp_t none;
        reset      = 1'b1;
        ir_n       = 1'b1;
        model_code = '0;
        model_have = 1'b0;
        none.kind  = -1;
        none.code  = '0;
        none.at    = -1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_code", code, 0);
        chk("rst_valid", code_valid, 0);
        chk("rst_repeat", repeat_hit, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        run('{pick(8000), pick(1750), pick(300)});
        chk("code_after_early_rpt", code, model_code);

        run('{7000});
        chk("busy_after_short_lead", busy, 0);

        build(32'h916E02FD, ph);
        run(ph);
        chk("code_hold_1", code, model_code);

        build(32'h916E926D, ph);
        run(ph);
        run('{9000, 2250, 560});
        chk("code_after_rpt", code, model_code);

        for (int n = 0; n < 2; n++) begin
            int j;
            build($urandom, ph);
            j = 2 * int'($urandom_range(1, 3)) + n;
            if (j % 2 == 0) ph[j] = int'($urandom_range(900, 1100));
            else            ph[j] = int'($urandom_range(850, 1150));
            while (ph.size() > j + 1) void'(ph.pop_back());
            if (j % 2 == 1) ph.push_back(pick(300));
            run(ph);
        end

        build($urandom, ph);
        while (ph.size() > 37) void'(ph.pop_back());
        run(ph);
        chk("code_after_timeout", code, model_code);

        build($urandom, ph);
        while (ph.size() > 40) void'(ph.pop_back());
        drive(ph, -5, none);
        ir_n = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_code", code, 0);
        chk("midrst_valid", code_valid, 0);
        chk("midrst_repeat", repeat_hit, 0);
        chk("midrst_err", err, 0);
        chk("midrst_busy", busy, 0);
        model_code = '0;
        model_have = 1'b0;
        ir_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        build(32'h916E12ED, ph);
        run(ph);
        chk("code_final", code, model_code);
        chk("busy_final", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
